flash_read_arbiter: RTL and testbench

Shares the single flash-controller read port between several read requesters, e.g. the audio sample reader and a secondary reader such as a waveform or display fetcher. Each requester sees its own port with the same handshake semantics as the flash controller. The arbiter grants requesters round-robin and allows one outstanding flash read at a time. It routes `flsh_readdatavalid` back to the granted requester only, and optionally recovers from a flash read that never returns data.

---
 rtl/flash_arb_pkg.sv | 28 ++
 rtl/flash_read_arbiter_rr_arbiter.sv | 33 +++
 rtl/flash_read_arbiter.sv | 182 ++++++++++++++++++
 tb/tb_flash_read_arbiter.sv | 359 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/flash_arb_pkg.sv
// Shared types and constants for the flash read arbiter.
package flash_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_ISSUE     = 2'd1,
        ST_WAIT_DATA = 2'd2
    } arb_state_t;

    localparam int FLASH_DATA_W = 32;
    localparam int FLASH_BE_W   = 4;
    localparam logic [FLASH_DATA_W-1:0] TIMEOUT_DATA = 32'h0000_0000;

    // Width of the data-timeout counter: wide enough for the limit, clamped to 8..16 bits.
    function automatic int timeout_cnt_w(input int timeout_cyc);
        int w;
        w = $clog2(timeout_cyc + 1);
        if (w < 8) begin
            w = 8;
        end else if (w > 16) begin
            w = 16;
        end else begin
            w = w;
        end
        return w;
    endfunction

endpackage

// File: rtl/flash_read_arbiter_rr_arbiter.sv
// Combinational round-robin picker: searches from last_grant+1 upward,
// wrapping modulo NUM_REQ, and reports the first active request.
module rr_arbiter
    import flash_arb_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int GW      = $clog2(NUM_REQ)
)(
    input  logic [NUM_REQ-1:0] req,
    input  logic [GW-1:0]      last_grant,
    output logic               valid,
    output logic [GW-1:0]      winner
);

    logic [GW-1:0] idx_s;

    // Rotating priority search; the first hit after last_grant wins.
    always_comb begin
        valid  = 1'b0;
        winner = {GW{1'b0}};
        idx_s  = {GW{1'b0}};
        for (int i = 1; i <= NUM_REQ; i++) begin
            idx_s = GW'((int'(last_grant) + i) % NUM_REQ);
            if (!valid && req[idx_s]) begin
                valid  = 1'b1;
                winner = idx_s;
            end else begin
                valid = valid;
            end
        end
    end

endmodule

// File: rtl/flash_read_arbiter.sv
// Flash read-port arbiter: round-robin grant between NUM_REQ requesters,
// one outstanding flash read at a time, readdatavalid routed to the owner.
// Optional build macro FLASH_ARB_TIMEOUT_EN adds a data timeout that issues a
// synthetic zero-data valid and sets a sticky timeout_err flag.
module flash_read_arbiter
    import flash_arb_pkg::*;
#(
    parameter int NUM_REQ     = 2,
    parameter int ADDR_W      = 23,
    parameter int TIMEOUT_CYC = 255
)(
    input  logic                           clk,
    input  logic                           reset,
    input  logic [NUM_REQ-1:0]             req_read,
    input  logic [NUM_REQ*ADDR_W-1:0]      req_address,
    input  logic [NUM_REQ*FLASH_BE_W-1:0]  req_byteenable,
    output logic [NUM_REQ-1:0]             req_waitrequest,
    output logic [FLASH_DATA_W-1:0]        req_readdata,
    output logic [NUM_REQ-1:0]             req_readdatavalid,
    output logic                           flsh_read,
    output logic [ADDR_W-1:0]              flsh_address,
    output logic [FLASH_BE_W-1:0]          flsh_byteenable,
    input  logic                           flsh_waitrequest,
    input  logic [FLASH_DATA_W-1:0]        flsh_readdata,
    input  logic                           flsh_readdatavalid,
    output logic [$clog2(NUM_REQ)-1:0]     grant_id,
    output logic                           busy,
    output logic                           timeout_err,
    output logic [15:0]                    debug
);

    localparam int GW = $clog2(NUM_REQ);

    arb_state_t            state_r;
    arb_state_t            state_nxt_s;
    logic [GW-1:0]         last_grant_r;
    logic [GW-1:0]         grant_id_r;
    logic [GW-1:0]         winner_s;
    logic                  pick_valid_s;
    logic [ADDR_W-1:0]     addr_r;
    logic [FLASH_BE_W-1:0] be_r;
    logic                  timeout_fire_s;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .GW      (GW)
    ) u_rr (
        .req        (req_read),
        .last_grant (last_grant_r),
        .valid      (pick_valid_s),
        .winner     (winner_s)
    );

`ifdef FLASH_ARB_TIMEOUT_EN
    localparam int CNT_W = timeout_cnt_w(TIMEOUT_CYC);

    logic [CNT_W-1:0] to_cnt_r;
    logic             timeout_err_r;

    // Counts cycles spent in WAIT_DATA; held at zero while issuing so entry starts from 0.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            to_cnt_r <= {CNT_W{1'b0}};
        end else if (state_r == ST_ISSUE) begin
            to_cnt_r <= {CNT_W{1'b0}};
        end else if (state_r == ST_WAIT_DATA) begin
            to_cnt_r <= to_cnt_r + CNT_W'(1);
        end else begin
            to_cnt_r <= to_cnt_r;
        end
    end

    assign timeout_fire_s = (state_r == ST_WAIT_DATA) && !flsh_readdatavalid &&
                            (to_cnt_r == CNT_W'(TIMEOUT_CYC));

    // Sticky error flag, cleared only by reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            timeout_err_r <= 1'b0;
        end else if (timeout_fire_s) begin
            timeout_err_r <= 1'b1;
        end else begin
            timeout_err_r <= timeout_err_r;
        end
    end

    assign timeout_err = timeout_err_r;
`else
    assign timeout_fire_s = 1'b0;
    assign timeout_err    = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (pick_valid_s) begin
                    state_nxt_s = ST_ISSUE;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                if (!flsh_waitrequest) begin
                    state_nxt_s = ST_WAIT_DATA;
                end else begin
                    state_nxt_s = ST_ISSUE;
                end
            end
            ST_WAIT_DATA: begin
                if (flsh_readdatavalid || timeout_fire_s) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_WAIT_DATA;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // Latch the winning transaction at grant time so a dropped request still completes.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_grant_r <= GW'(NUM_REQ - 1);
            grant_id_r   <= {GW{1'b0}};
            addr_r       <= {ADDR_W{1'b0}};
            be_r         <= {FLASH_BE_W{1'b0}};
        end else if ((state_r == ST_IDLE) && pick_valid_s) begin
            last_grant_r <= winner_s;
            grant_id_r   <= winner_s;
            addr_r       <= req_address[int'(winner_s)*ADDR_W +: ADDR_W];
            be_r         <= req_byteenable[int'(winner_s)*FLASH_BE_W +: FLASH_BE_W];
        end else begin
            last_grant_r <= last_grant_r;
            grant_id_r   <= grant_id_r;
            addr_r       <= addr_r;
            be_r         <= be_r;
        end
    end

    // Output decode: waitrequest and valid are passed straight through to the owner only.
    always_comb begin
        req_waitrequest   = {NUM_REQ{1'b1}};
        req_readdatavalid = {NUM_REQ{1'b0}};
        flsh_read         = 1'b0;
        case (state_r)
            ST_IDLE: begin
                flsh_read = 1'b0;
            end
            ST_ISSUE: begin
                flsh_read                   = 1'b1;
                req_waitrequest[grant_id_r] = flsh_waitrequest;
            end
            ST_WAIT_DATA: begin
                req_readdatavalid[grant_id_r] = flsh_readdatavalid | timeout_fire_s;
            end
            default: begin
                flsh_read = 1'b0;
            end
        endcase
    end

    assign req_readdata    = timeout_fire_s ? TIMEOUT_DATA : flsh_readdata;
    assign flsh_address    = addr_r;
    assign flsh_byteenable = be_r;
    assign grant_id        = grant_id_r;
    assign busy            = (state_r != ST_IDLE);
    assign debug           = {timeout_err, busy, 2'b00, 4'(grant_id_r), 4'b0000, 2'b00, state_r};

endmodule

// File: tb/tb_flash_read_arbiter.sv
// Self-checking bench for flash_read_arbiter: scripted vector table,
// hand-written multi-cycle sequences and a randomized run against a
// transaction-level reference model.
module tb_flash_read_arbiter;

    localparam int NR = 2;
    localparam int AW = 23;
    localparam int TO = 20;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic [NR-1:0]   req_read;
    logic [NR*AW-1:0] req_address;
    logic [NR*4-1:0] req_byteenable;
    logic [NR-1:0]   req_waitrequest;
    logic [31:0]     req_readdata;
    logic [NR-1:0]   req_readdatavalid;
    logic            flsh_read;
    logic [AW-1:0]   flsh_address;
    logic [3:0]      flsh_byteenable;
    logic            flsh_waitrequest;
    logic [31:0]     flsh_readdata;
    logic            flsh_readdatavalid;
    logic [0:0]      grant_id;
    logic            busy;
    logic            timeout_err;
    logic [15:0]     debug;

    int n_chk  = 0;
    int n_fail = 0;

    flash_read_arbiter #(.NUM_REQ(NR), .ADDR_W(AW), .TIMEOUT_CYC(TO)) dut (
        .clk                (clk),
        .reset              (reset),
        .req_read           (req_read),
        .req_address        (req_address),
        .req_byteenable     (req_byteenable),
        .req_waitrequest    (req_waitrequest),
        .req_readdata       (req_readdata),
        .req_readdatavalid  (req_readdatavalid),
        .flsh_read          (flsh_read),
        .flsh_address       (flsh_address),
        .flsh_byteenable    (flsh_byteenable),
        .flsh_waitrequest   (flsh_waitrequest),
        .flsh_readdata      (flsh_readdata),
        .flsh_readdatavalid (flsh_readdatavalid),
        .grant_id           (grant_id),
        .busy               (busy),
        .timeout_err        (timeout_err),
        .debug              (debug)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Inputs change 1 time unit after the rising edge; outputs are sampled 3 units later.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_fread"}, flsh_read, 32'd0);
        chk({tag, "_faddr"}, flsh_address, 32'd0);
        chk({tag, "_fbe"}, flsh_byteenable, 32'd0);
        chk({tag, "_wr"}, req_waitrequest, 32'd3);
        chk({tag, "_dv"}, req_readdatavalid, 32'd0);
        chk({tag, "_busy"}, busy, 32'd0);
        chk({tag, "_gid"}, grant_id, 32'd0);
        chk({tag, "_toerr"}, timeout_err, 32'd0);
        chk({tag, "_debug"}, debug, 32'd0);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        req_read = 2'b00;
        flsh_waitrequest = 1'b1;
        flsh_readdatavalid = 1'b0;
        flsh_readdata = 32'h0;
        step();
        step();
        reset = 1'b0;
    endtask

    // One complete read by requester r with the given flash stall and read latency.
    task automatic one_read(input int r, input logic [22:0] a, input int stall, input int lat,
                            input logic [31:0] d);
        logic [1:0] oh;
        logic [1:0] nw;
        oh = 2'b01 << r;
        nw = ~oh;
        req_address[r*AW +: AW] = a;
        req_read = oh;
        flsh_waitrequest = 1'b1;
        flsh_readdatavalid = 1'b0;
        #3;
        chk("rd_idle_busy", busy, 32'd0);
        chk("rd_idle_fread", flsh_read, 32'd0);
        step();
        for (int s = 0; s < stall; s++) begin
            #3;
            chk("rd_stall_fread", flsh_read, 32'd1);
            chk("rd_stall_wr", req_waitrequest, 32'd3);
            step();
        end
        flsh_waitrequest = 1'b0;
        #3;
        chk("rd_issue_fread", flsh_read, 32'd1);
        chk("rd_issue_addr", flsh_address, 32'(a));
        chk("rd_issue_gid", grant_id, 32'(r));
        chk("rd_issue_wr", req_waitrequest, 32'(nw));
        step();
        req_read = 2'b00;
        flsh_waitrequest = 1'b1;
        for (int l = 0; l < lat; l++) begin
            #3;
            chk("rd_wait_dv", req_readdatavalid, 32'd0);
            chk("rd_wait_fread", flsh_read, 32'd0);
            step();
        end
        flsh_readdatavalid = 1'b1;
        flsh_readdata = d;
        #3;
        chk("rd_data_dv", req_readdatavalid, 32'(oh));
        chk("rd_data_rdata", req_readdata, d);
        step();
        flsh_readdatavalid = 1'b0;
    endtask

    typedef struct {
        logic [1:0]  rr;
        logic        fw;
        logic        fv;
        logic [31:0] fd;
        logic        e_fr;
        logic [22:0] e_addr;
        logic [1:0]  e_wr;
        logic [1:0]  e_dv;
        logic        e_gid;
        logic        e_busy;
    } vec_t;

    vec_t vt[14];

    // Random-test model state
    logic [1:0]  rv;
    logic [22:0] ra[NR];
    logic [22:0] gaddr;
    int          lw, gid_m, owner, lat;
    bit          freeb, acc, drop, found;
    logic        fw_c, fv_c;
    logic [31:0] fd_c;
    logic [1:0]  e_wr, e_dv;

    initial begin
        req_read = 2'b00;
        req_address = '0;
        req_byteenable = {4'hC, 4'h3};
        flsh_waitrequest = 1'b1;
        flsh_readdata = 32'h0;
        flsh_readdatavalid = 1'b0;

        // ---- reset state ----
        do_reset();
        #3;
        chk_reset_vals("reset");

        // ---- scripted vector table (starts in IDLE, requester 0 first) ----
        //           rr     fw    fv    fd              fr    addr       wr     dv     gid   busy
        vt[0]  = '{2'b11, 1'b1, 1'b0, 32'h0,          1'b0, 23'h000, 2'b11, 2'b00, 1'b0, 1'b0};
        vt[1]  = '{2'b11, 1'b1, 1'b0, 32'h0,          1'b1, 23'h100, 2'b11, 2'b00, 1'b0, 1'b1};
        vt[2]  = '{2'b11, 1'b1, 1'b0, 32'h0,          1'b1, 23'h100, 2'b11, 2'b00, 1'b0, 1'b1};
        vt[3]  = '{2'b11, 1'b1, 1'b0, 32'h0,          1'b1, 23'h100, 2'b11, 2'b00, 1'b0, 1'b1};
        vt[4]  = '{2'b11, 1'b0, 1'b0, 32'h0,          1'b1, 23'h100, 2'b10, 2'b00, 1'b0, 1'b1};
        vt[5]  = '{2'b10, 1'b1, 1'b0, 32'h0,          1'b0, 23'h000, 2'b11, 2'b00, 1'b0, 1'b1};
        vt[6]  = '{2'b10, 1'b1, 1'b0, 32'h0,          1'b0, 23'h000, 2'b11, 2'b00, 1'b0, 1'b1};
        vt[7]  = '{2'b10, 1'b1, 1'b0, 32'h0,          1'b0, 23'h000, 2'b11, 2'b00, 1'b0, 1'b1};
        vt[8]  = '{2'b10, 1'b1, 1'b1, 32'hABCD1234,   1'b0, 23'h000, 2'b11, 2'b01, 1'b0, 1'b1};
        vt[9]  = '{2'b10, 1'b1, 1'b0, 32'h0,          1'b0, 23'h000, 2'b11, 2'b00, 1'b0, 1'b0};
        vt[10] = '{2'b10, 1'b0, 1'b0, 32'h0,          1'b1, 23'h200, 2'b01, 2'b00, 1'b1, 1'b1};
        vt[11] = '{2'b00, 1'b1, 1'b1, 32'h5555AAAA,   1'b0, 23'h000, 2'b11, 2'b10, 1'b1, 1'b1};
        vt[12] = '{2'b00, 1'b1, 1'b1, 32'h00000077,   1'b0, 23'h000, 2'b11, 2'b00, 1'b1, 1'b0};
        vt[13] = '{2'b00, 1'b0, 1'b1, 32'h00000077,   1'b0, 23'h000, 2'b11, 2'b00, 1'b1, 1'b0};
        req_address[0*AW +: AW] = 23'h100;
        req_address[1*AW +: AW] = 23'h200;
        for (int i = 0; i < 14; i++) begin
            req_read = vt[i].rr;
            flsh_waitrequest = vt[i].fw;
            flsh_readdatavalid = vt[i].fv;
            flsh_readdata = vt[i].fd;
            #3;
            chk($sformatf("tbl%0d_fread", i), flsh_read, 32'(vt[i].e_fr));
            chk($sformatf("tbl%0d_wr", i), req_waitrequest, 32'(vt[i].e_wr));
            chk($sformatf("tbl%0d_dv", i), req_readdatavalid, 32'(vt[i].e_dv));
            chk($sformatf("tbl%0d_gid", i), grant_id, 32'(vt[i].e_gid));
            chk($sformatf("tbl%0d_busy", i), busy, 32'(vt[i].e_busy));
            if (vt[i].e_fr) begin
                chk($sformatf("tbl%0d_addr", i), flsh_address, 32'(vt[i].e_addr));
                chk($sformatf("tbl%0d_be", i), flsh_byteenable, vt[i].e_gid ? 32'hC : 32'h3);
            end
            if (vt[i].e_dv != 2'b00) begin
                chk($sformatf("tbl%0d_rdata", i), req_readdata, vt[i].fd);
            end
            step();
        end

        // ---- requester 1 alone: ten back-to-back reads, none reach requester 0 ----
        do_reset();
        for (int k = 0; k < 10; k++) begin
            one_read(1, 23'(32'h4000 + k), $urandom_range(0, 2), $urandom_range(0, 3), $urandom);
        end

        // ---- reset during WAIT_DATA, then a late valid ----
        do_reset();
        req_address[0*AW +: AW] = 23'h0ABC;
        req_read = 2'b01;
        step();
        flsh_waitrequest = 1'b0;
        step();
        req_read = 2'b00;
        flsh_waitrequest = 1'b1;
        #3;
        chk("rstmid_busy_before", busy, 32'd1);
        reset = 1'b1;
        #1;
        chk_reset_vals("rstmid_async");
        flsh_readdatavalid = 1'b1;
        flsh_readdata = 32'h12345678;
        #1;
        chk("rstmid_dv_in_reset", req_readdatavalid, 32'd0);
        step();
        reset = 1'b0;
        #3;
        chk("rstmid_dv_late", req_readdatavalid, 32'd0);
        chk_reset_vals("rstmid_after");
        step();
        flsh_readdatavalid = 1'b0;

`ifdef FLASH_ARB_TIMEOUT_EN
        // ---- flash never answers: synthetic zero valid after TO cycles in WAIT_DATA ----
        do_reset();
        req_address[0*AW +: AW] = 23'h0321;
        req_read = 2'b01;
        step();
        flsh_waitrequest = 1'b0;
        step();
        req_read = 2'b00;
        flsh_waitrequest = 1'b1;
        flsh_readdata = 32'hDEADBEEF;
        for (int c = 0; c < TO; c++) begin
            #3;
            chk("to_wait_dv", req_readdatavalid, 32'd0);
            chk("to_wait_busy", busy, 32'd1);
            step();
        end
        #3;
        chk("to_fire_dv", req_readdatavalid, 32'd1);
        chk("to_fire_rdata", req_readdata, 32'h0);
        step();
        #3;
        chk("to_err_set", timeout_err, 32'd1);
        chk("to_idle", busy, 32'd0);
        chk("to_debug", debug, 32'h8000);
        step();
        one_read(0, 23'h0555, 1, 2, 32'hCAFEF00D);
        #3;
        chk("to_err_sticky", timeout_err, 32'd1);
        step();
`endif

        // ---- randomized traffic against a transaction-level model ----
        do_reset();
        rv = 2'b00;
        lw = NR - 1;
        gid_m = 0;
        owner = 0;
        lat = 0;
        freeb = 1'b1;
        acc = 1'b0;
        gaddr = 23'h0;
        for (int i = 0; i < NR; i++) ra[i] = 23'h0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            fw_c = ($urandom_range(0, 2) == 0);
            if (!freeb && acc && lat == 0) fv_c = 1'b1;
            else if (!freeb && acc) fv_c = 1'b0;
            else fv_c = ($urandom_range(0, 7) == 0);
            fd_c = $urandom;
            req_read = rv;
            for (int i = 0; i < NR; i++) req_address[i*AW +: AW] = ra[i];
            flsh_waitrequest = fw_c;
            flsh_readdatavalid = fv_c;
            flsh_readdata = fd_c;
            #3;
            e_wr = 2'b11;
            e_dv = 2'b00;
            if (!freeb && !acc) e_wr[owner] = fw_c;
            if (!freeb && acc && lat == 0) e_dv[owner] = 1'b1;
            chk("rnd_fread", flsh_read, 32'(!freeb && !acc));
            chk("rnd_wr", req_waitrequest, 32'(e_wr));
            chk("rnd_dv", req_readdatavalid, 32'(e_dv));
            chk("rnd_busy", busy, 32'(!freeb));
            chk("rnd_gid", grant_id, 32'(gid_m));
            if (!freeb && !acc) chk("rnd_addr", flsh_address, 32'(gaddr));
            if (e_dv != 2'b00) chk("rnd_rdata", req_readdata, fd_c);
            // model advance
            drop = 1'b0;
            if (freeb) begin
                if (rv != 2'b00) begin
                    found = 1'b0;
                    for (int k = 1; k <= NR; k++) begin
                        if (!found && rv[(lw + k) % NR]) begin
                            owner = (lw + k) % NR;
                            found = 1'b1;
                        end
                    end
                    lw = owner;
                    gid_m = owner;
                    gaddr = ra[owner];
                    freeb = 1'b0;
                    acc = 1'b0;
                end
            end else if (!acc) begin
                if (!fw_c) begin
                    acc = 1'b1;
                    lat = $urandom_range(0, 4);
                    drop = 1'b1;
                end
            end else begin
                if (lat == 0) freeb = 1'b1;
                else lat--;
            end
            for (int i = 0; i < NR; i++) begin
                if (drop && i == owner) rv[i] = 1'b0;
                else if (!rv[i] && $urandom_range(0, 3) == 0) begin
                    rv[i] = 1'b1;
                    ra[i] = 23'($urandom);
                end
            end
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
